// File: rtl/box_filter_decimator.sv
// Decimating FIFO stage behind box_filter: drops warm-up samples, keeps every
// DECIM-th sample after that, and buffers kept samples for a valid/ready consumer.
//
// state  | meaning
// WARMUP | upstream window still filling; valid samples are discarded
// RUN    | decimating; phase 0 samples are kept and pushed to the FIFO
module box_filter_decimator #(
    parameter int FILTER_SIZE = 4,
    parameter int DECIM       = 4,
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             clear,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [WW-1:0] WARM_LAST  = WW'((FILTER_SIZE > 1) ? FILTER_SIZE - 2 : 0);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    typedef enum logic {WARMUP, RUN} state_t;
    localparam state_t RST_STATE = (FILTER_SIZE > 1) ? WARMUP : RUN;

    state_t          state_q, state_d;
    logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic keep, push, pop, drop, full, empty;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready;

    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        phase_d      = phase_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        keep         = 1'b0;

        case (state_q)
            WARMUP: begin
                if (in_valid) begin
                    warm_cnt_d = warm_cnt_q + WW'(1);
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    keep    = (phase_q == '0);
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase

        // A full FIFO can still take a sample when the head leaves on the same edge.
        push = keep && (!full || pop);
        drop = keep && !push;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        if (clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            warm_cnt_q   <= '0;
            phase_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            phase_q      <= phase_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in;
    end

    assign out_valid  = !empty;
    assign out        = empty ? '0 : mem_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_box_filter_decimator.sv
// Directed bench for box_filter_decimator: default instance plus a
// FILTER_SIZE=1 / DECIM=1 instance for the no-warm-up and saturation cases.
module tb_box_filter_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv1 = 1'b0, rdy1 = 1'b0, clr1 = 1'b0;
    logic [31:0] din1 = '0;
    logic        ov1, ovf1;
    logic [31:0] o1;
    logic [15:0] dc1;

    logic        iv2 = 1'b0, rdy2 = 1'b0, clr2 = 1'b0;
    logic [31:0] din2 = '0;
    logic        ov2, ovf2;
    logic [31:0] o2;
    logic [15:0] dc2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        rdy;
        logic        exp_v;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    box_filter_decimator dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in(din1), .out_valid(ov1),
        .out_ready(rdy1), .out(o1), .clear(clr1), .overflow(ovf1), .drop_count(dc1)
    );

    box_filter_decimator #(.FILTER_SIZE(1), .DECIM(1), .DEPTH(8), .WIDTH(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in(din2), .out_valid(ov2),
        .out_ready(rdy2), .out(o2), .clear(clr2), .overflow(ovf2), .drop_count(dc2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] din, input logic rdy,
                       input logic ev, input logic [31:0] eo);
        vec_t v;
        v.iv = iv; v.din = din; v.rdy = rdy; v.exp_v = ev; v.exp_out = eo;
        vecs.push_back(v);
    endtask

    task automatic drive(input int sel, input logic iv, input logic [31:0] din, input logic rdy);
        if (sel == 1) begin iv1 = iv; din1 = din; rdy1 = rdy; end
        else          begin iv2 = iv; din2 = din; rdy2 = rdy; end
    endtask

    task automatic apply_vecs(input int sel, input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(sel, vecs[i].iv, vecs[i].din, vecs[i].rdy);
            @(negedge clk);
            if (sel == 1) begin
                check($sformatf("%s[%0d].valid", tag, i), {31'd0, ov1}, {31'd0, vecs[i].exp_v});
                check($sformatf("%s[%0d].out", tag, i), o1, vecs[i].exp_out);
            end else begin
                check($sformatf("%s[%0d].valid", tag, i), {31'd0, ov2}, {31'd0, vecs[i].exp_v});
                check($sformatf("%s[%0d].out", tag, i), o2, vecs[i].exp_out);
            end
        end
        vecs.delete();
        drive(sel, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b0, 32'd0, 1'b0);
        drive(2, 1'b0, 32'd0, 1'b0);
        clr1 = 1'b0; clr2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: warm-up discard, first kept sample, gaps do not advance phase
        do_reset();
        check("rst.out_valid", {31'd0, ov1}, 32'd0);
        check("rst.out", o1, 32'd0);
        check("rst.overflow", {31'd0, ovf1}, 32'd0);
        check("rst.drop_count", {16'd0, dc1}, 32'd0);
        add(1, 10, 1, 0, 0);   add(1, 20, 1, 0, 0);  add(1, 30, 1, 0, 0);
        add(1, 40, 1, 1, 40);  add(1, 50, 1, 0, 0);  add(1, 60, 1, 0, 0);
        add(1, 70, 1, 0, 0);   add(1, 80, 1, 1, 80); add(1, 90, 1, 0, 0);
        add(0, 999, 1, 0, 0);  add(1, 100, 1, 0, 0); add(0, 999, 1, 0, 0);
        add(0, 999, 1, 0, 0);  add(1, 110, 1, 0, 0); add(1, 120, 1, 1, 120);
        add(0, 0, 1, 0, 0);
        apply_vecs(1, "warmup");

        // 2: no warm-up, DECIM=1, gaps produce nothing
        do_reset();
        for (int v = 1; v <= 16; v++) begin
            add(1, 32'(v * 3), 1, 1, 32'(v * 3));
            if (v == 4 || v == 9 || v == 13) add(0, 777, 1, 0, 0);
        end
        add(0, 0, 1, 0, 0);
        apply_vecs(2, "dec1");

        // 3: backpressure, overflow, ordered drain with stable head
        do_reset();
        for (int i = 1; i <= 44; i++) begin
            drive(1, 1'b1, 32'(i), 1'b0);
            @(negedge clk);
            if (i >= 4) begin
                check($sformatf("stall[%0d].valid", i), {31'd0, ov1}, 32'd1);
                check($sformatf("stall[%0d].out", i), o1, 32'd4);
            end
        end
        check("bp.overflow", {31'd0, ovf1}, 32'd1);
        check("bp.drop_count", {16'd0, dc1}, 32'd3);
        drive(1, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain[%0d].valid", k), {31'd0, ov1}, 32'd1);
            check($sformatf("drain[%0d].out", k), o1, 32'((k + 1) * 4));
            @(negedge clk);
        end
        check("drain.empty_valid", {31'd0, ov1}, 32'd0);
        check("drain.empty_out", o1, 32'd0);
        check("drain.drop_count", {16'd0, dc1}, 32'd3);

        // 4: full FIFO with a pop on the same edge as a kept sample
        do_reset();
        for (int i = 1; i <= 35; i++) begin
            drive(1, 1'b1, 32'(i), 1'b0);
            @(negedge clk);
        end
        drive(1, 1'b1, 32'd36, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 32'd0, 1'b0);
        check("fullpop.drop_count", {16'd0, dc1}, 32'd0);
        check("fullpop.overflow", {31'd0, ovf1}, 32'd0);
        check("fullpop.head", o1, 32'd8);
        rdy1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fpdrain[%0d].valid", k), {31'd0, ov1}, 32'd1);
            check($sformatf("fpdrain[%0d].out", k), o1, 32'((k + 2) * 4));
            @(negedge clk);
        end
        check("fpdrain.empty", {31'd0, ov1}, 32'd0);
        rdy1 = 1'b0;

        // 5: drop_count saturation and clear priority over a drop
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(2, 1'b1, 32'(i), 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 65535; i++) begin
            drive(2, 1'b1, 32'hABCD, 1'b0);
            @(negedge clk);
        end
        check("sat.drop_count", {16'd0, dc2}, 32'h0000FFFF);
        check("sat.overflow", {31'd0, ovf2}, 32'd1);
        repeat (5) @(negedge clk);
        check("sat.hold", {16'd0, dc2}, 32'h0000FFFF);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("clr.overflow", {31'd0, ovf2}, 32'd0);
        check("clr.drop_count", {16'd0, dc2}, 32'd0);
        @(negedge clk);
        drive(2, 1'b0, 32'd0, 1'b0);
        check("postclr.drop_count", {16'd0, dc2}, 32'd1);
        check("postclr.overflow", {31'd0, ovf2}, 32'd1);
        check("postclr.head", o2, 32'd1);

        // 6: async reset between edges with 5 entries buffered
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1'b1, 32'(i), 1'b0);
            @(negedge clk);
        end
        drive(1, 1'b0, 32'd0, 1'b0);
        check("prerst.valid", {31'd0, ov1}, 32'd1);
        check("prerst.out", o1, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", {31'd0, ov1}, 32'd0);
        check("arst.out", o1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        add(1, 101, 1, 0, 0);   add(1, 102, 1, 0, 0);
        add(1, 103, 1, 0, 0);   add(1, 104, 1, 1, 104);
        add(0, 0, 1, 0, 0);
        apply_vecs(1, "rewarm");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
